tl_tx_class_router: RTL and testbench
=====================================

Name: tl_tx_class_router

Overview:
- Parametrised successor to the TX queue routing stage. Sits between the payload mux and the Posted, Non-Posted and Completion TX queues.
- Decodes the full Fmt/Type space of each TLP header beat and routes the whole packet to its ordering class.
- Each class output is buffered in a per-class skid FIFO.
- Unsupported TLPs are dropped whole and counted. Framing violations are flagged.

Parameters:
- SKID_DEPTH, 2, entries per class output FIFO; power of two, minimum 2.
- CNT_W, 16, width of the saturating drop counter.
- CFGWR_POSTED, 0, 1 routes CfgWr to Posted (legacy mode); 0 routes it to Non-Posted (PCIe-correct).
- DROP_EN, 1, 1 drops unsupported TLPs; 0 routes them to Posted.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pkt_i  in  tl_stream_t  input beat (data, sop, eop)
- pkt_valid_i  in  1  input valid
- pkt_ready_o  out  1  input ready
- pkt_posted_o  out  tl_stream_t  Posted class beat
- pkt_posted_valid_o  out  1  Posted class valid
- pkt_posted_ready_i  in  1  Posted class ready
- pkt_np_o  out  tl_stream_t  Non-Posted class beat
- pkt_np_valid_o  out  1  Non-Posted class valid
- pkt_np_ready_i  in  1  Non-Posted class ready
- pkt_cpl_o  out  tl_stream_t  Completion class beat
- pkt_cpl_valid_o  out  1  Completion class valid
- pkt_cpl_ready_i  in  1  Completion class ready
- drop_cnt_o  out  CNT_W  count of dropped packets, saturating
- err_sop_o  out  1  sticky: SOP seen while inside a packet
- err_orphan_o  out  1  sticky: non-SOP beat seen while idle

Behaviour:
- Reset values:
  - All valid outputs 0; stream outputs '0.
  - drop_cnt_o = 0; err_sop_o = 0; err_orphan_o = 0.
  - All FIFOs empty; FSM in IDLE.
- Decode (SOP beat only): fmt = data[7:5], type = data[4:0].
  - MRd: fmt 000/001, type 00000 or 00001 -> NP.
  - MWr: fmt 010/011, type 00000 -> Posted.
  - IORd/IOWr: type 00010 -> NP.
  - CfgRd0/1: fmt 000, type 00100/00101 -> NP.
  - CfgWr0/1: fmt 010, type 00100/00101 -> NP, or Posted when CFGWR_POSTED = 1.
  - Msg/MsgD: type 10xxx -> Posted.
  - Cpl/CplD/CplLk/CplDLk: type 01010/01011 -> CPL.
  - Atomics: fmt 010/011, type 01100..01110 -> NP.
  - Anything else -> UNSUP.
- FSM states: IDLE, FWD (class locked), DROP.
  - IDLE, accepted SOP:
    - Supported class, or UNSUP with DROP_EN = 0: lock the class.
    - UNSUP with DROP_EN = 1: go to DROP and increment drop_cnt.
    - If eop is also set: complete the packet and stay in IDLE.
  - FWD: beats go to the locked class. Accepted eop -> IDLE.
  - DROP: pkt_ready_o = 1 and beats are discarded. Accepted eop -> IDLE.
  - IDLE, accepted non-SOP beat: discard it, set err_orphan_o, stay in IDLE.
  - FWD or DROP, accepted SOP: set err_sop_o and treat the beat as a new packet start (re-decode and re-lock). No synthetic EOP is generated for the truncated packet.
- Handshake:
  - Accept = pkt_valid_i & pkt_ready_o.
  - pkt_ready_o = !full of the target class FIFO; 1 in DROP or for orphan beats.
  - Target class = decoded class on SOP, locked class otherwise.
  - pkt_ready_o must not depend on pkt_*_ready_i (no combinational ready path).
- FIFOs:
  - Latency: an accepted beat appears on its class output in the next cycle.
  - A FIFO push and pop in the same cycle when full is legal only if pop happens; push is gated by !full before the pop.
  - Throughput: 1 beat/cycle per class when SKID_DEPTH >= 2.
  - Output valid = !empty; data = head entry. Outputs hold stable while valid & !ready.
  - Classes drain independently; a stalled class never blocks another class's already-queued beats.
- drop_cnt_o saturates at 2^CNT_W-1. Error flags clear only on reset.
- Reset mid-packet: FIFOs flushed, FSM to IDLE. The next non-SOP beat is orphaned.

Test Plan:
- Single-beat MRd (data[7:0] = 8'h00, sop = eop = 1), NP ready = 1 -> pkt_np_valid_o = 1 next cycle, other valids 0, FSM stays IDLE.
- 4-beat MWr (data[7:0] = 8'h40) with pkt_posted_ready_i = 0 -> 2 beats accepted, then pkt_ready_o = 0. Release ready -> all 4 beats out in order, eop on beat 4.
- CfgWr0 (8'h44): CFGWR_POSTED = 0 -> NP; CFGWR_POSTED = 1 -> Posted.
- Unsupported type 8'h1F, 3 beats, DROP_EN = 1 -> no output valid, pkt_ready_o = 1 throughout, drop_cnt_o 0 -> 1. CNT_W = 2 with 5 drops -> saturates at 3.
- CplD (8'h4A) stalled on CPL while an MRd follows -> MRd is held because input is in order, but previously queued NP beats drain. Complete the CPL -> MRd appears on NP.
- Framing errors:
  - SOP mid-MWr -> err_sop_o = 1, new packet routed.
  - Non-SOP beat in IDLE -> err_orphan_o = 1, beat discarded.
  - Assert rst_n = 0 mid-packet -> all valids 0 and flags cleared.

Source files
------------

// File: rtl/tl_tx_class_router.sv
// tl_tx_class_router: decodes TLP headers and routes whole packets into per-class skid FIFOs.
// Unsupported packets are dropped and counted, and framing violations raise sticky flags.
package tl_pkg;
    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } tl_stream_t;
endpackage

module tl_tx_class_router
    import tl_pkg::*;
#(
    parameter int SKID_DEPTH   = 2,
    parameter int CNT_W        = 16,
    parameter int CFGWR_POSTED = 0,
    parameter int DROP_EN      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  tl_stream_t       pkt_i,
    input  logic             pkt_valid_i,
    output logic             pkt_ready_o,
    output tl_stream_t       pkt_posted_o,
    output logic             pkt_posted_valid_o,
    input  logic             pkt_posted_ready_i,
    output tl_stream_t       pkt_np_o,
    output logic             pkt_np_valid_o,
    input  logic             pkt_np_ready_i,
    output tl_stream_t       pkt_cpl_o,
    output logic             pkt_cpl_valid_o,
    input  logic             pkt_cpl_ready_i,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic             err_sop_o,
    output logic             err_orphan_o
);
    localparam int AW = $clog2(SKID_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(SKID_DEPTH);
    localparam logic [1:0] C_P = 2'd0, C_NP = 2'd1, C_CPL = 2'd2, C_UN = 2'd3;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    function automatic logic [1:0] decode(input logic [7:0] h);
        logic [2:0] f;
        logic [4:0] t;
        f = h[7:5];
        t = h[4:0];
        decode = C_UN;
        if (f[2:1] == 2'b00 && t[4:1] == 4'b0000)
            decode = C_NP;
        else if (f[2:1] == 2'b01 && t == 5'b00000)
            decode = C_P;
        else if (t == 5'b00010)
            decode = C_NP;
        else if (f == 3'b000 && t[4:1] == 4'b0010)
            decode = C_NP;
        else if (f == 3'b010 && t[4:1] == 4'b0010)
            decode = (CFGWR_POSTED != 0) ? C_P : C_NP;
        else if (t[4:3] == 2'b10)
            decode = C_P;
        else if (t[4:1] == 4'b0101)
            decode = C_CPL;
        else if (f[2:1] == 2'b01 && t >= 5'b01100 && t <= 5'b01110)
            decode = C_NP;
    endfunction

    state_t     state_q, state_d;
    logic [1:0] lock_q, lock_d, dec, tgt;
    logic       dec_drop, drop_beat, acc;
    logic [2:0] full, empty, push, pop, out_rdy;
    tl_stream_t head [3];

    assign dec       = decode(pkt_i.data[7:0]);
    assign dec_drop  = (dec == C_UN) && (DROP_EN != 0);
    // Unsupported packets fall back to Posted when dropping is disabled
    assign tgt       = pkt_i.sop ? ((dec == C_UN) ? C_P : dec) : lock_q;
    assign drop_beat = pkt_i.sop ? dec_drop : (state_q != FWD);
    assign acc       = pkt_valid_i & pkt_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lock_q       <= C_P;
            drop_cnt_o   <= '0;
            err_sop_o    <= 1'b0;
            err_orphan_o <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            if (acc && pkt_i.sop && dec_drop && !(&drop_cnt_o))
                drop_cnt_o <= drop_cnt_o + 1'b1;
            if (acc && pkt_i.sop && (state_q != IDLE))
                err_sop_o <= 1'b1;
            if (acc && !pkt_i.sop && (state_q == IDLE))
                err_orphan_o <= 1'b1;
        end
    end

    always_comb begin
        state_d = !acc ? state_q :
                  pkt_i.sop ? (pkt_i.eop ? IDLE : dec_drop ? DROP : FWD) :
                  pkt_i.eop ? IDLE : state_q;
        lock_d  = (acc && pkt_i.sop) ? tgt : lock_q;
    end

    // Ready looks only at FIFO occupancy, never at the downstream readies
    always_comb begin
        pkt_ready_o = drop_beat | ~full[tgt];
        for (int i = 0; i < 3; i++)
            push[i] = pkt_valid_i & ~drop_beat & ~full[i] & (tgt == 2'(i));
    end

    assign out_rdy = {pkt_cpl_ready_i, pkt_np_ready_i, pkt_posted_ready_i};

    for (genvar c = 0; c < 3; c++) begin : g_fifo
        tl_stream_t    mem [SKID_DEPTH];
        logic [AW-1:0] wp, rp;
        logic [AW:0]   cnt;
        assign full[c]  = cnt == DEPTH;
        assign empty[c] = cnt == '0;
        assign pop[c]   = ~empty[c] & out_rdy[c];
        assign head[c]  = empty[c] ? '0 : mem[rp];
        always_ff @(posedge clk) begin
            if (push[c])
                mem[wp] <= pkt_i;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                wp  <= wp + AW'(push[c]);
                rp  <= rp + AW'(pop[c]);
                cnt <= cnt + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
            end
        end
    end

    assign pkt_posted_o       = head[0];
    assign pkt_posted_valid_o = ~empty[0];
    assign pkt_np_o           = head[1];
    assign pkt_np_valid_o     = ~empty[1];
    assign pkt_cpl_o          = head[2];
    assign pkt_cpl_valid_o    = ~empty[2];
endmodule

// File: tb/tb_tl_tx_class_router.sv
// tb_tl_tx_class_router: directed stimulus against a queue-based class model, plus literal pins.
module tb_tl_tx_class_router;
    import tl_pkg::*;

    localparam int DEPTH    = 2;
    localparam int CFGWR_P  = 0;
    localparam int DROP_EN  = 1;
    localparam int CNT_MAX  = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    tl_stream_t  pkt_i, pk_p, pk_np, pk_cpl;
    logic        pkt_valid_i, pkt_ready_o;
    logic        p_valid, np_valid, cpl_valid;
    logic        p_ready, np_ready, cpl_ready;
    logic [15:0] drop_cnt;
    logic        err_sop, err_orphan;

    tl_stream_t  a_pkt, a_p, a_np, a_cpl;
    logic        a_valid, a_ready, a_p_valid, a_np_valid, a_cpl_valid;
    logic [1:0]  a_drop;
    logic        a_err_sop, a_err_orphan;

    int n_chk = 0;
    int n_err = 0;
    int tag = 1;

    always #5 clk = ~clk;

    tl_tx_class_router u_dut (
        .clk(clk), .rst_n(rst_n),
        .pkt_i(pkt_i), .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
        .pkt_posted_o(pk_p), .pkt_posted_valid_o(p_valid), .pkt_posted_ready_i(p_ready),
        .pkt_np_o(pk_np), .pkt_np_valid_o(np_valid), .pkt_np_ready_i(np_ready),
        .pkt_cpl_o(pk_cpl), .pkt_cpl_valid_o(cpl_valid), .pkt_cpl_ready_i(cpl_ready),
        .drop_cnt_o(drop_cnt), .err_sop_o(err_sop), .err_orphan_o(err_orphan)
    );

    tl_tx_class_router #(.CNT_W(2), .CFGWR_POSTED(1)) u_alt (
        .clk(clk), .rst_n(rst_n),
        .pkt_i(a_pkt), .pkt_valid_i(a_valid), .pkt_ready_o(a_ready),
        .pkt_posted_o(a_p), .pkt_posted_valid_o(a_p_valid), .pkt_posted_ready_i(1'b1),
        .pkt_np_o(a_np), .pkt_np_valid_o(a_np_valid), .pkt_np_ready_i(1'b1),
        .pkt_cpl_o(a_cpl), .pkt_cpl_valid_o(a_cpl_valid), .pkt_cpl_ready_i(1'b1),
        .drop_cnt_o(a_drop), .err_sop_o(a_err_sop), .err_orphan_o(a_err_orphan)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Class per TLP name: 0 Posted, 1 Non-Posted, 2 Completion, 3 unsupported
    function automatic int m_class(input logic [7:0] h);
        casez (h)
            8'b00?_0000?: return 1;
            8'b01?_00000: return 0;
            8'b???_00010: return 1;
            8'b000_0010?: return 1;
            8'b010_0010?: return CFGWR_P ? 0 : 1;
            8'b???_10???: return 0;
            8'b???_0101?: return 2;
            8'b01?_01100, 8'b01?_01101, 8'b01?_01110: return 1;
            default: return 3;
        endcase
    endfunction

    tl_stream_t mq [3][$];
    int m_st = 0;
    int m_cls = 0;
    int m_cnt = 0;
    logic m_esop = 1'b0;
    logic m_eorph = 1'b0;

    function automatic logic m_ready();
        int c;
        if (pkt_i.sop) begin
            c = m_class(pkt_i.data[7:0]);
            if (c == 3)
                return DROP_EN ? 1'b1 : (mq[0].size() < DEPTH);
            return mq[c].size() < DEPTH;
        end
        if (m_st != 1)
            return 1'b1;
        return mq[m_cls].size() < DEPTH;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic a;
        int c;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) mq[k].delete();
            m_st <= 0; m_cls <= 0; m_cnt <= 0; m_esop <= 1'b0; m_eorph <= 1'b0;
        end else begin
            a = pkt_valid_i && m_ready();
            if (p_ready && mq[0].size() != 0) void'(mq[0].pop_front());
            if (np_ready && mq[1].size() != 0) void'(mq[1].pop_front());
            if (cpl_ready && mq[2].size() != 0) void'(mq[2].pop_front());
            if (a && pkt_i.sop) begin
                if (m_st != 0) m_esop <= 1'b1;
                c = m_class(pkt_i.data[7:0]);
                if (c == 3 && DROP_EN) begin
                    if (m_cnt != CNT_MAX) m_cnt <= m_cnt + 1;
                    m_st <= pkt_i.eop ? 0 : 2;
                end else begin
                    if (c == 3) c = 0;
                    mq[c].push_back(pkt_i);
                    m_cls <= c;
                    m_st <= pkt_i.eop ? 0 : 1;
                end
            end else if (a) begin
                if (m_st == 0) m_eorph <= 1'b1;
                else begin
                    if (m_st == 1) mq[m_cls].push_back(pkt_i);
                    if (pkt_i.eop) m_st <= 0;
                end
            end
        end
    end

    always begin
        logic [2:0] dv;
        tl_stream_t dd [3];
        @(negedge clk);
        #2;
        dv = {cpl_valid, np_valid, p_valid};
        dd[0] = pk_p; dd[1] = pk_np; dd[2] = pk_cpl;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("valid_cls%0d", c), dv[c], mq[c].size() != 0);
            if (mq[c].size() != 0)
                chk($sformatf("data_cls%0d", c), dd[c], mq[c][0]);
        end
        chk("ready", pkt_ready_o, m_ready());
        chk("drop_cnt", drop_cnt, m_cnt);
        chk("err_sop", err_sop, m_esop);
        chk("err_orphan", err_orphan, m_eorph);
    end

    task automatic beat(input logic [7:0] h, input logic s, input logic e);
        int n = 0;
        pkt_i.data = {tag[23:0], h};
        tag++;
        pkt_i.sop = s;
        pkt_i.eop = e;
        pkt_valid_i = 1'b1;
        #1;
        while (!pkt_ready_o && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", pkt_ready_o, 1'b1);
        @(negedge clk);
        pkt_valid_i = 1'b0;
    endtask

    task automatic a_beat(input logic [7:0] h);
        int n = 0;
        a_pkt = '{data: {24'h0, h}, sop: 1'b1, eop: 1'b1};
        a_valid = 1'b1;
        #1;
        while (!a_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("alt_accept", a_ready, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        pkt_valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] hdr_t [18] = '{8'h00, 8'h20, 8'h01, 8'h40, 8'h60, 8'h02, 8'h42, 8'h04, 8'h45,
                               8'h30, 8'h74, 8'h0A, 8'h4B, 8'h4C, 8'h6E, 8'h4F, 8'h24, 8'h64};
    int cls_t [18] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 2, 2, 1, 1, 3, 3, 3};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        pkt_i = '0; pkt_valid_i = 1'b0;
        a_pkt = '0; a_valid = 1'b0;
        p_ready = 1'b1; np_ready = 1'b1; cpl_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valids", {cpl_valid, np_valid, p_valid}, 3'b000);
        chk("rst_drop_cnt", drop_cnt, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        beat(8'h00, 1'b1, 1'b1);
        #1;
        chk("mrd_np_valid", np_valid, 1'b1);
        chk("mrd_p_valid", p_valid, 1'b0);
        idle(2);

        p_ready = 1'b0;
        beat(8'h40, 1'b1, 1'b0);
        beat(8'h11, 1'b0, 1'b0);
        pkt_i = '{data: {24'(tag), 8'h22}, sop: 1'b0, eop: 1'b0};
        pkt_valid_i = 1'b1;
        #1;
        chk("mwr_stall_ready", pkt_ready_o, 1'b0);
        fork
            beat(8'h22, 1'b0, 1'b0);
            begin
                repeat (3) @(negedge clk);
                p_ready = 1'b1;
            end
        join
        beat(8'h33, 1'b0, 1'b1);
        idle(4);

        beat(8'h44, 1'b1, 1'b1);
        #1;
        chk("cfgwr_np_valid", np_valid, 1'b1);
        idle(2);

        beat(8'h1F, 1'b1, 1'b0);
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h02, 1'b0, 1'b1);
        chk("unsup_drop_cnt", drop_cnt, 16'd1);
        chk("unsup_no_valid", {cpl_valid, np_valid, p_valid}, 3'b000);
        idle(2);

        np_ready = 1'b0; cpl_ready = 1'b0;
        beat(8'h00, 1'b1, 1'b1);
        beat(8'h4A, 1'b1, 1'b0);
        beat(8'h11, 1'b0, 1'b0);
        fork
            begin
                beat(8'h22, 1'b0, 1'b1);
                beat(8'h00, 1'b1, 1'b1);
                #1;
                chk("mrd_after_cpl", np_valid, 1'b1);
            end
            begin
                repeat (2) @(negedge clk);
                np_ready = 1'b1;
                repeat (2) @(negedge clk);
                #3;
                chk("np_drained", np_valid, 1'b0);
                chk("cpl_stalled", cpl_valid, 1'b1);
                chk("in_order_hold", pkt_ready_o, 1'b0);
                cpl_ready = 1'b1;
            end
        join
        idle(3);

        beat(8'h40, 1'b1, 1'b0);
        beat(8'h55, 1'b0, 1'b0);
        beat(8'h00, 1'b1, 1'b1);
        #1;
        chk("sop_err_flag", err_sop, 1'b1);
        chk("sop_rerouted_np", np_valid, 1'b1);
        idle(3);

        beat(8'h66, 1'b0, 1'b0);
        #1;
        chk("orphan_flag", err_orphan, 1'b1);
        chk("orphan_discard", {cpl_valid, np_valid, p_valid}, 3'b000);
        idle(2);

        for (int i = 0; i < 18; i++) begin
            beat(hdr_t[i], 1'b1, 1'b1);
            #1;
            chk($sformatf("route_%h", hdr_t[i]), {cpl_valid, np_valid, p_valid},
                (cls_t[i] == 3) ? 0 : (1 << cls_t[i]));
        end
        chk("table_drop_cnt", drop_cnt, 16'd4);
        idle(3);

        p_ready = 1'b0;
        beat(8'h40, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valids", {cpl_valid, np_valid, p_valid}, 3'b000);
        chk("rst_mid_flags", {err_sop, err_orphan}, 2'b00);
        chk("rst_mid_cnt", drop_cnt, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p_ready = 1'b1;
        @(negedge clk);
        beat(8'h77, 1'b0, 1'b1);
        #1;
        chk("post_rst_orphan", err_orphan, 1'b1);
        chk("post_rst_no_valid", p_valid, 1'b0);
        idle(2);

        a_beat(8'h44);
        #1;
        chk("alt_cfgwr_posted", {a_np_valid, a_p_valid}, 2'b01);
        a_beat(8'h1F);
        a_beat(8'h1F);
        chk("alt_drop_2", a_drop, 2'd2);
        a_beat(8'h1F);
        a_beat(8'h1F);
        a_beat(8'h1F);
        chk("alt_drop_sat", a_drop, 2'd3);
        chk("alt_no_valid", {a_cpl_valid, a_np_valid, a_p_valid}, 3'b000);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
